// File: rtl/down_count_monitor_pkg.sv
// Shared types and constants for the down-counter sequence monitor.
//   dcm_state_t  : FSM state encoding (IDLE=0, ACQUIRE=1, LOCKED=2, 3 unused)
//   DCM_*        : default widths for the monitor and its counters
//   dcm_expected : next expected down-count value, modulo 2^w
package down_count_monitor_pkg;

  localparam int unsigned DCM_WIDTH      = 4;
  localparam int unsigned DCM_ERR_CNT_W  = 8;
  localparam int unsigned DCM_WRAP_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } dcm_state_t;

  // prev - 1 truncated to w bits, so 0 wraps to all-ones
  function automatic logic [31:0] dcm_expected(input logic [31:0] prev,
                                               input int unsigned w);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (prev - 32'd1) & mask;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
//   clk, rst : clock, synchronous active-high reset
//   inc      : increment request
//   cnt      : current count
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/down_count_monitor.sv
// Sequence monitor for a free-running down counter. Locks after LOCK_LEN
// consecutive good decrements, then flags mismatches, terminal count and
// completed wraps.
//   clk, rst     : clock, synchronous active-high reset
//   cnt_in       : observed count, sampled when cnt_valid=1
//   locked       : high while in LOCKED
//   tc_pulse     : one cycle after a locked sample of 0
//   err_pulse    : one cycle after a mismatch while LOCKED
//   err_count    : saturating error count
//   wrap_count   : saturating count of locked 0 -> max transitions
//   state_o      : FSM state for debug
// Optional (DOWN_COUNT_MONITOR_STICKY_EN):
//   err_clr      : clears err_sticky (err_pulse wins on the same cycle)
//   err_sticky   : latched error flag
module down_count_monitor
  import down_count_monitor_pkg::*;
#(
  parameter int unsigned WIDTH      = DCM_WIDTH,
  parameter int unsigned ERR_CNT_W  = DCM_ERR_CNT_W,
  parameter int unsigned WRAP_CNT_W = DCM_WRAP_CNT_W,
  parameter int unsigned LOCK_LEN   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      cnt_in,
  input  logic                  cnt_valid,
`ifdef DOWN_COUNT_MONITOR_STICKY_EN
  input  logic                  err_clr,
  output logic                  err_sticky,
`endif
  output logic                  locked,
  output logic                  tc_pulse,
  output logic                  err_pulse,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic [WRAP_CNT_W-1:0] wrap_count,
  output logic [1:0]            state_o
);

  localparam int unsigned RUN_W = (LOCK_LEN < 2) ? 1 : $clog2(LOCK_LEN + 1);
  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

  dcm_state_t       state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             locked_q, locked_d;
  logic             tc_q, tc_d;
  logic             err_q, err_d;
  logic             wrap_inc;

  logic [WIDTH-1:0] expected;
  logic             match;
  logic             run_done;
  logic             accept_locked;

  assign expected = WIDTH'(dcm_expected(32'(prev_q), WIDTH));
  assign match    = cnt_valid && (cnt_in == expected);
  assign run_done = ((32'(run_q) + 32'd1) == LOCK_LEN);
  // A good sample either inside LOCKED or the one that completes lock
  assign accept_locked = match &&
                         ((state_q == LOCKED) || ((state_q == ACQUIRE) && run_done));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cnt_valid) state_d = ACQUIRE;
      ACQUIRE: if (match && run_done) state_d = LOCKED;
      LOCKED:  if (cnt_valid && !match) state_d = ACQUIRE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    prev_d   = cnt_valid ? cnt_in : prev_q;
    run_d    = run_q;
    err_d    = 1'b0;
    locked_d = (state_d == LOCKED);
    tc_d     = accept_locked && (cnt_in == '0);
    wrap_inc = accept_locked && (prev_q == '0) && (cnt_in == MAX_VAL);
    case (state_q)
      IDLE: begin
        if (cnt_valid) run_d = '0;
      end
      ACQUIRE: begin
        if (cnt_valid) begin
          if (match && !run_done) run_d = run_q + RUN_W'(1);
          else                    run_d = '0;
        end
      end
      LOCKED: begin
        if (cnt_valid && !match) begin
          err_d = 1'b1;
          run_d = '0;
        end
      end
      default: run_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q   <= '0;
      run_q    <= '0;
      locked_q <= 1'b0;
      tc_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      run_q    <= run_d;
      locked_q <= locked_d;
      tc_q     <= tc_d;
      err_q    <= err_d;
    end
  end

  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_d),
    .cnt (err_count)
  );

  sat_counter #(.W(WRAP_CNT_W)) u_wrap_cnt (
    .clk (clk),
    .rst (rst),
    .inc (wrap_inc),
    .cnt (wrap_count)
  );

`ifdef DOWN_COUNT_MONITOR_STICKY_EN
  logic sticky_q;

  // Set wins over clear so an error in the clearing cycle is not lost
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else if (err_d) begin
      sticky_q <= 1'b1;
    end else if (err_clr) begin
      sticky_q <= 1'b0;
    end
  end

  assign err_sticky = sticky_q;
`endif

  assign locked    = locked_q;
  assign tc_pulse  = tc_q;
  assign err_pulse = err_q;
  assign state_o   = state_q;

endmodule

// File: doc/down_count_monitor.md
Name: down_count_monitor

Overview:
- Downstream consumer of the 4-bit down counter's count output.
- Checks every sampled value against the expected decrement, modulo 2^WIDTH (0 -> 15 is legal).
- Acquires lock after a run of consecutive good samples, then flags sequence errors and terminal count (0), and counts completed wraps.
- Used as a self-checking monitor beside counter instances in simulation and FPGA bring-up.

Parameters:
WIDTH, 4, width of the monitored count.
ERR_CNT_W, 8, width of the saturating error counter.
WRAP_CNT_W, 8, width of the saturating wrap counter.
LOCK_LEN, 2, consecutive good decrements needed to enter LOCKED (must be >= 1).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous active-high reset.
cnt_in  in  WIDTH  count value from the down counter.
cnt_valid  in  1  sample cnt_in this cycle; tie to 1 for a free-running counter.
locked  out  1  high while in LOCKED.
tc_pulse  out  1  one-cycle pulse: a locked sample equal to 0.
err_pulse  out  1  one-cycle pulse: a mismatch detected while LOCKED.
err_count  out  ERR_CNT_W  saturating count of err_pulse events.
wrap_count  out  WRAP_CNT_W  saturating count of locked 0 -> max transitions.
state_o  out  2  current FSM state encoding, for debug.

Behaviour:
- Reset: synchronous, active-high on clk. Every output and internal register is 0 on the edge where rst=1: locked, tc_pulse, err_pulse, err_count, wrap_count, prev sample, good-run counter; state = IDLE.
- rst can assert mid-operation. It takes priority over all other activity and discards the history.
- expected = prev - 1, truncated to WIDTH bits (wraps 0 -> 2^WIDTH-1).
- match = cnt_valid && (cnt_in == expected).
- Whenever cnt_valid=1, prev <= cnt_in, in every state.
- cnt_valid=0: FSM, prev and counters hold; pulses deassert.
- FSM states, encoded IDLE=0, ACQUIRE=1, LOCKED=2, code 3 unused:
  - IDLE: on valid, capture prev and go to ACQUIRE with run=0.
  - ACQUIRE, valid and match: run+1. When run+1 == LOCK_LEN, go to LOCKED; locked rises on the same edge.
  - ACQUIRE, valid and mismatch: run=0, stay in ACQUIRE. The new sample becomes the reference. No error is flagged.
  - LOCKED, valid and match: stay in LOCKED.
  - LOCKED, valid and mismatch: err_pulse=1 next cycle, err_count+1 (saturating), go to ACQUIRE with run=0, locked drops.
  - Unused code 3: recover to IDLE on the next edge.
- Pulse latency: tc_pulse and err_pulse are registered, high for exactly the one cycle after the triggering sample edge.
- tc_pulse fires on a sample of 0 that is accepted as a match in LOCKED. This includes the sample that completes lock.
- wrap_count: +1 (saturating) when prev==0, cnt_in==2^WIDTH-1 and match, in LOCKED or on the locking edge.
- A held value (cnt_in == prev) is a mismatch.
- Saturating counters stop at all-ones and never wrap.
- Simultaneous error and saturation: err_pulse still fires; err_count stays at max.
- LOCK_LEN=1: a single matching sample after IDLE locks.

Optional Feature:
- Macro: DOWN_COUNT_MONITOR_STICKY_EN.
- Defined:
  - Adds input err_clr (1 bit) and output err_sticky (1 bit).
  - err_sticky sets on any err_pulse and holds until err_clr=1 or rst.
  - Set has priority over err_clr in the same cycle.
  - err_clr does not clear err_count.
- Not defined: neither port exists, and behaviour is otherwise identical.

Decomposition:
- Package down_count_monitor_pkg:
  - state enum type dcm_state_t (IDLE, ACQUIRE, LOCKED), 2-bit;
  - default width constants DCM_WIDTH=4, DCM_ERR_CNT_W=8, DCM_WRAP_CNT_W=8;
  - function for the modular expected value.
- One sub-module: sat_counter.
  - Parameter W; inputs clk, rst, inc; output cnt.
  - Synchronous reset; saturating increment.
  - Instantiated twice, for err_count and wrap_count.

Test Plan:
- Reset, then cnt_valid=1 with cnt_in = 9,8,7 -> locked=1 on the edge of sample 7; err_count=0; state_o=2.
- Locked free-run 3,2,1,0,15,14 -> tc_pulse high one cycle after the 0 sample; wrap_count=1 after the 15 sample; no err_pulse.
- Locked at 6, then inject 6 (hold), then 5,4 -> err_pulse one cycle, err_count=1, locked=0, then relock after 5,4.
- Force 256+ errors with ERR_CNT_W=8 -> err_count stops at 255; err_pulse still pulses on each error.
- cnt_valid=0 for 3 cycles mid-lock, then resume with the next decrement -> state, prev and counters unchanged; no err_pulse.
- rst=1 for one cycle while locked with err_count=3 -> next cycle all outputs 0, state IDLE; relock requires LOCK_LEN+1 samples. With DOWN_COUNT_MONITOR_STICKY_EN: err_sticky=1 after an error, cleared by a one-cycle err_clr pulse.
